// File: rtl/avst_pkg.sv
// Shared types and helpers for the Avalon-ST packet capture sink.
package avst_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DROP    = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int bytes_per_beat(input int width);
    return width / 8;
  endfunction

  // Saturating increment for a counter of the given width (up to 64 bits).
  function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (cnt >= max_v) ? cnt : cnt + 64'd1;
  endfunction

endpackage

// File: rtl/avst_bp_gen.sv
// Deterministic backpressure pattern: stall asserted one cycle in eight.
// Only instantiated when AVST_SINK_BACKPRESSURE_EN is defined.
module avst_bp_gen (
  input  logic clk,
  input  logic rst,
  output logic stall
);

  logic [2:0] cnt_q, cnt_d;

  // Free-running phase counter
  always_comb cnt_d = cnt_q + 3'd1;

  // Phase counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 3'd0;
    else     cnt_q <= cnt_d;
  end

  assign stall = (cnt_q == 3'd4);

endmodule

// File: rtl/avst_pkt_capture_sink.sv
// Avalon-ST sink capturing one packet into a DEPTH-beat buffer, with channel
// filtering, overflow/framing statistics and host handshake.
// Optional macro AVST_SINK_BACKPRESSURE_EN adds a 1-in-8 ready throttle.
module avst_pkt_capture_sink
  import avst_pkg::*;
#(
  parameter int                           WIDTH       = 64,
  parameter int                           EMPTY_WIDTH = $clog2(WIDTH/8),
  parameter int                           DEPTH       = 8,
  parameter int                           CH_WIDTH    = 2,
  parameter logic [(2**CH_WIDTH)-1:0]     CH_MASK     = '1,
  parameter int                           CNT_WIDTH   = 16
)(
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WIDTH-1:0]                   data,
  input  logic                               valid,
  output logic                               ready,
  input  logic                               sop,
  input  logic                               eop,
  input  logic [EMPTY_WIDTH-1:0]             empty,
  input  logic [CH_WIDTH-1:0]                channel,
  output logic                               pkt_valid,
  input  logic                               pkt_ack,
  output logic [$clog2(DEPTH+1)-1:0]         pkt_beats,
  output logic [$clog2(DEPTH*WIDTH/8+1)-1:0] pkt_bytes,
  output logic [CH_WIDTH-1:0]                pkt_channel,
  output logic                               pkt_overflow,
  input  logic [$clog2(DEPTH)-1:0]           rd_addr,
  output logic [WIDTH-1:0]                   rd_data,
  output logic [CNT_WIDTH-1:0]               orphan_cnt,
  output logic [CNT_WIDTH-1:0]               abort_cnt,
  output logic [CNT_WIDTH-1:0]               drop_cnt
);

  localparam int BPB     = bytes_per_beat(WIDTH);
  localparam int IDX_W   = $clog2(DEPTH+1);
  localparam int BYTES_W = $clog2(DEPTH*WIDTH/8+1);
  localparam int AW      = $clog2(DEPTH);

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 pkt_valid_q, pkt_valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CH_WIDTH-1:0]  ch_q, ch_d;
  logic                 ovf_q, ovf_d;
  logic [BYTES_W-1:0]   bytes_q, bytes_d;
  logic [CNT_WIDTH-1:0] orphan_q, orphan_d;
  logic [CNT_WIDTH-1:0] abort_q, abort_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [WIDTH-1:0]     buf_q [DEPTH];

  logic                 xfer;
  logic                 do_sop;
  logic                 pkt_end;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;

  // Empty beyond the bus byte count is treated as the largest legal value.
  function automatic logic [BYTES_W-1:0] clamp_empty(input logic [EMPTY_WIDTH-1:0] e);
    if (int'(e) > BPB - 1) return BYTES_W'(BPB - 1);
    else                   return BYTES_W'(e);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    return CNT_WIDTH'(sat_inc(64'(c), CNT_WIDTH));
  endfunction

  assign xfer = valid && ready;

  // Next-state, capture bookkeeping and statistics
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ch_d     = ch_q;
    ovf_d    = ovf_q;
    bytes_d  = bytes_q;
    orphan_d = orphan_q;
    abort_d  = abort_q;
    drop_d   = drop_q;
    wr_en    = 1'b0;
    wr_addr  = '0;
    do_sop   = 1'b0;
    pkt_end  = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (sop) do_sop   = 1'b1;
          else     orphan_d = cnt_inc(orphan_q);
        end
      end
      CAPTURE: begin
        if (xfer) begin
          if (sop) begin
            do_sop  = 1'b1;
            abort_d = cnt_inc(abort_q);
          end else begin
            if (int'(idx_q) < DEPTH) begin
              wr_en   = 1'b1;
              wr_addr = AW'(idx_q);
              idx_d   = idx_q + IDX_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
            if (eop) begin
              state_d = DONE;
              pkt_end = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (xfer) begin
          if (sop)      do_sop  = 1'b1;
          else if (eop) state_d = IDLE;
        end
      end
      DONE: begin
        if (pkt_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start-of-packet beat behaves identically whichever state sees it.
    if (do_sop) begin
      if (CH_MASK[channel]) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        idx_d   = IDX_W'(1);
        ch_d    = channel;
        ovf_d   = 1'b0;
        state_d = eop ? DONE : CAPTURE;
        pkt_end = eop;
      end else begin
        drop_d  = cnt_inc(drop_q);
        state_d = eop ? IDLE : DROP;
      end
    end

    if (pkt_end) begin
      if (ovf_d) bytes_d = BYTES_W'(DEPTH * BPB);
      else       bytes_d = BYTES_W'(int'(idx_d) * BPB) - clamp_empty(empty);
    end

    ready_d     = (state_d != DONE);
    pkt_valid_d = (state_d == DONE);
  end

  // State, registered outputs and capture buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      idx_q       <= '0;
      ch_q        <= '0;
      ovf_q       <= 1'b0;
      bytes_q     <= '0;
      orphan_q    <= '0;
      abort_q     <= '0;
      drop_q      <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      pkt_valid_q <= pkt_valid_d;
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      ovf_q       <= ovf_d;
      bytes_q     <= bytes_d;
      orphan_q    <= orphan_d;
      abort_q     <= abort_d;
      drop_q      <= drop_d;
      if (wr_en) buf_q[wr_addr] <= data;
    end
  end

  // Combinational buffer read, zero outside the buffer
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < DEPTH) rd_data = buf_q[rd_addr];
  end

`ifdef AVST_SINK_BACKPRESSURE_EN
  logic bp_stall;

  avst_bp_gen u_bp_gen (
    .clk   (clk),
    .rst   (rst),
    .stall (bp_stall)
  );

  assign ready = ready_q & ~bp_stall;
`else
  assign ready = ready_q;
`endif

  assign pkt_valid    = pkt_valid_q;
  assign pkt_beats    = idx_q;
  assign pkt_bytes    = bytes_q;
  assign pkt_channel  = ch_q;
  assign pkt_overflow = ovf_q;
  assign orphan_cnt   = orphan_q;
  assign abort_cnt    = abort_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_avst_pkt_capture_sink.sv
// Bench for avst_pkt_capture_sink: table of packet shapes, hand-written
// framing/reset/filter sequences, and randomized packets against a model.
module tb_avst_pkt_capture_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data;
  logic        valid, sop, eop, pkt_ack;
  logic [2:0]  empty;
  logic [1:0]  channel;
  logic [2:0]  rd_addr;

  logic        ready0, pkt_valid0, ovf0;
  logic [3:0]  beats0;
  logic [6:0]  bytes0;
  logic [1:0]  pch0;
  logic [63:0] rd0;
  logic [15:0] orph0, abrt0, drop0;

  logic        ready1, pkt_valid1, ovf1;
  logic [3:0]  beats1;
  logic [6:0]  bytes1;
  logic [1:0]  pch1;
  logic [63:0] rd1;
  logic [1:0]  orph1, abrt1, drop1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  avst_pkt_capture_sink dut0 (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready0),
    .sop(sop), .eop(eop), .empty(empty), .channel(channel),
    .pkt_valid(pkt_valid0), .pkt_ack(pkt_ack), .pkt_beats(beats0),
    .pkt_bytes(bytes0), .pkt_channel(pch0), .pkt_overflow(ovf0),
    .rd_addr(rd_addr), .rd_data(rd0), .orphan_cnt(orph0),
    .abort_cnt(abrt0), .drop_cnt(drop0)
  );

  avst_pkt_capture_sink #(.CH_MASK(4'b0001), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready1),
    .sop(sop), .eop(eop), .empty(empty), .channel(channel),
    .pkt_valid(pkt_valid1), .pkt_ack(pkt_ack), .pkt_beats(beats1),
    .pkt_bytes(bytes1), .pkt_channel(pch1), .pkt_overflow(ovf1),
    .rd_addr(rd_addr), .rd_data(rd1), .orphan_cnt(orph1),
    .abort_cnt(abrt1), .drop_cnt(drop1)
  );

  typedef struct {
    int         len;
    logic [1:0] ch;
    logic [2:0] emp;
    int         exp_beats;
    int         exp_bytes;
    logic       exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_word(input logic [63:0] base, input int i);
    return base + 64'(i + 1) * 64'h11;
  endfunction

  // Called at a negedge; returns at the negedge following the transfer.
  task automatic send_beat(input logic [63:0] d, input logic s, input logic e,
                           input logic [2:0] em, input logic [1:0] c);
    int tmo;
    data = d; sop = s; eop = e; empty = em; channel = c; valid = 1'b1;
    tmo = 0;
    while (!ready0 && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (!ready0) check("send_timeout", 64'(ready0), 64'd1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Non-SOP beats carry random channel and non-EOP beats random empty.
  task automatic send_pkt(input int len, input logic [1:0] ch, input logic [2:0] emp,
                          input logic [63:0] base, input bit close);
    for (int i = 0; i < len; i++) begin
      logic last;
      last = close && (i == len - 1);
      send_beat(beat_word(base, i), i == 0, last,
                last ? emp : 3'($urandom_range(0, 7)),
                (i == 0) ? ch : 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic check_pkt(input string tag, input int eb, input int ebytes,
                           input logic eovf, input logic [1:0] ch, input logic [63:0] base);
    check({tag, "_valid"}, 64'(pkt_valid0), 64'd1);
    check({tag, "_ready"}, 64'(ready0), 64'd0);
    check({tag, "_beats"}, 64'(beats0), 64'(eb));
    check({tag, "_bytes"}, 64'(bytes0), 64'(ebytes));
    check({tag, "_chan"},  64'(pch0), 64'(ch));
    check({tag, "_ovf"},   64'(ovf0), 64'(eovf));
    for (int i = 0; i < eb; i++) begin
      rd_addr = 3'(i);
      #1;
      check({tag, "_rd"}, rd0, beat_word(base, i));
    end
    @(negedge clk);
    check({tag, "_hold_valid"}, 64'(pkt_valid0), 64'd1);
    check({tag, "_hold_ready"}, 64'(ready0), 64'd0);
    check({tag, "_hold_beats"}, 64'(beats0), 64'(eb));
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
    check({tag, "_ack_valid"}, 64'(pkt_valid0), 64'd0);
    check({tag, "_ack_ready"}, 64'(ready0), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; pkt_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  vec_t tbl[6];

  initial begin
    int exp_orph, exp_abort, rdy_cnt;
    rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; pkt_ack = 1'b0;
    data = '0; empty = '0; channel = '0; rd_addr = '0;

    tbl[0] = '{3,  2'd1, 3'd2, 3, 22, 1'b0};
    tbl[1] = '{1,  2'd0, 3'd0, 1, 8,  1'b0};
    tbl[2] = '{10, 2'd2, 3'd5, 8, 64, 1'b1};
    tbl[3] = '{8,  2'd3, 3'd7, 8, 57, 1'b0};
    tbl[4] = '{2,  2'd0, 3'd5, 2, 11, 1'b0};
    tbl[5] = '{9,  2'd1, 3'd0, 8, 64, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready0), 64'd0);
    check("rst_pkt_valid", 64'(pkt_valid0), 64'd0);
    check("rst_beats", 64'(beats0), 64'd0);
    check("rst_bytes", 64'(bytes0), 64'd0);
    check("rst_counters", {orph0, abrt0, drop0}, 64'd0);
    check("rst_rd", rd0, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 64'(ready0), 64'd1);

    // Idle ready pattern over 16 cycles
    rdy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (ready0) rdy_cnt++;
      @(negedge clk);
    end
`ifdef AVST_SINK_BACKPRESSURE_EN
    check("bp_ready_count", 64'(rdy_cnt), 64'd14);
`else
    check("idle_ready_count", 64'(rdy_cnt), 64'd16);
`endif

    // Table of packet shapes
    for (int t = 0; t < 6; t++) begin
      logic [63:0] base;
      base = 64'(t) << 32;
      send_pkt(tbl[t].len, tbl[t].ch, tbl[t].emp, base, 1'b1);
      check_pkt($sformatf("tbl%0d", t), tbl[t].exp_beats, tbl[t].exp_bytes,
                tbl[t].exp_ovf, tbl[t].ch, base);
    end

    // Orphans, abort by new SOP, counter saturation on the narrow instance
    do_reset();
    send_beat(64'hDEAD, 1'b0, 1'b0, 3'd0, 2'd0);
    send_beat(64'hBEEF, 1'b0, 1'b1, 3'd0, 2'd0);
    check("orphan_cnt", 64'(orph0), 64'd2);
    check("orphan_cnt_n", 64'(orph1), 64'd2);
    send_pkt(3, 2'd0, 3'd0, 64'h100, 1'b0);
    send_pkt(2, 2'd0, 3'd1, 64'hA00, 1'b1);
    check("abort_cnt", 64'(abrt0), 64'd1);
    check("abort_cnt_n", 64'(abrt1), 64'd1);
    check_pkt("abort_pkt", 2, 15, 1'b0, 2'd0, 64'hA00);
    for (int i = 0; i < 3; i++) send_beat(64'(i), 1'b0, 1'b0, 3'd0, 2'd0);
    check("orphan_cnt_more", 64'(orph0), 64'd5);
    check("orphan_cnt_sat", 64'(orph1), 64'd3);

    // Reset in the middle of a capture
    send_pkt(2, 2'd1, 3'd0, 64'h700, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(ready0), 64'd0);
    check("midrst_beats", 64'(beats0), 64'd0);
    check("midrst_counters", {orph0, abrt0, drop0}, 64'd0);
    rd_addr = 3'd1;
    #1;
    check("midrst_rd", rd0, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_ready", 64'(ready0), 64'd1);
    send_pkt(1, 2'd2, 3'd3, 64'h800, 1'b1);
    check_pkt("after_rst", 1, 5, 1'b0, 2'd2, 64'h800);
    check("after_rst_abort", 64'(abrt0), 64'd0);

    // Channel filter on the masked instance
    do_reset();
    send_pkt(3, 2'd2, 3'd0, 64'h500, 1'b1);
    check("filt_drop", 64'(drop1), 64'd1);
    check("filt_no_valid", 64'(pkt_valid1), 64'd0);
    check("filt_ready_n", 64'(ready1), 64'd1);
    check_pkt("filt_wide", 3, 24, 1'b0, 2'd2, 64'h500);
    send_pkt(2, 2'd0, 3'd3, 64'h600, 1'b1);
    check("filt_cap_valid", 64'(pkt_valid1), 64'd1);
    check("filt_cap_beats", 64'(beats1), 64'd2);
    check("filt_cap_bytes", 64'(bytes1), 64'd13);
    check("filt_cap_chan", 64'(pch1), 64'd0);
    check("filt_cap_ovf", 64'(ovf1), 64'd0);
    rd_addr = 3'd1;
    #1;
    check("filt_cap_rd", rd1, beat_word(64'h600, 1));
    check_pkt("filt_ch0", 2, 13, 1'b0, 2'd0, 64'h600);
    send_pkt(1, 2'd3, 3'd0, 64'h900, 1'b1);
    check("filt_drop_single", 64'(drop1), 64'd2);
    check("filt_single_idle", 64'(ready1), 64'd1);
    check("filt_single_novalid", 64'(pkt_valid1), 64'd0);
    check_pkt("filt_single_wide", 1, 8, 1'b0, 2'd3, 64'h900);
    check("filt_drop_wide", 64'(drop0), 64'd0);

    // Randomized packets against a counting model
    do_reset();
    exp_orph = 0;
    exp_abort = 0;
    for (int n = 0; n < 40; n++) begin
      int k, len, eb, ebytes;
      logic [1:0] ch;
      logic [2:0] emp;
      logic [63:0] base;
      logic eovf;
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++)
        send_beat({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      exp_orph += k;
      if ($urandom_range(0, 3) == 0) begin
        send_pkt($urandom_range(1, 3), 2'($urandom_range(0, 3)), 3'd0,
                 {$urandom, $urandom}, 1'b0);
        exp_abort++;
      end
      len  = $urandom_range(1, 12);
      ch   = 2'($urandom_range(0, 3));
      emp  = 3'($urandom_range(0, 7));
      base = {$urandom, $urandom};
      send_pkt(len, ch, emp, base, 1'b1);
      eovf   = (len > 8);
      eb     = eovf ? 8 : len;
      ebytes = eovf ? 64 : len * 8 - int'(emp);
      check_pkt($sformatf("rnd%0d", n), eb, ebytes, eovf, ch, base);
      check("rnd_orphan", 64'(orph0), 64'(exp_orph));
      check("rnd_abort", 64'(abrt0), 64'(exp_abort));
      check("rnd_drop", 64'(drop0), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
